reset_sequencer: RTL and testbench



---
 rtl/rst_seq_pkg.sv | 27 ++
 rtl/reset_sync_chain.sv | 29 ++
 rtl/reset_sequencer.sv | 149 ++++++++++++++
 tb/tb_reset_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// ---------------------------------------------------------------------------
// rst_seq_pkg : shared types and helpers for the reset sequencer
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rst_seq_pkg;

  localparam int MAX_DOMAINS = 8;
  localparam int IDX_W       = $clog2(MAX_DOMAINS);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } rst_seq_state_t;

  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/reset_sync_chain.sv
// ---------------------------------------------------------------------------
// reset_sync_chain : asynchronous-assert, synchronous-release reset flop chain
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reset_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_sync_no
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_no = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer : synchronised reset with hold stretch and staggered
//                   per-domain release. Macro RST_SEQ_SW_RST_EN enables the
//                   software reset request input.
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_DOMAINS = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_sw_rst_req,
  output logic [NUM_DOMAINS-1:0] o_rst_n,
  output logic                   o_all_released,
  output logic                   o_seq_busy
);

  localparam int                CNT_W     = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  logic                   rst_sync_n;
  logic                   sw_req;
  logic                   sw_act;
  logic                   hold_done;
  logic                   gap_done;

  rst_seq_state_t         state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   all_q, all_d;
  logic                   busy_q, busy_d;

  reset_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i       (i_clk),
    .rst_ni      (i_rst_n),
    .rst_sync_no (rst_sync_n)
  );

`ifdef RST_SEQ_SW_RST_EN
  assign sw_req = i_sw_rst_req;
`else
  assign sw_req = i_sw_rst_req & 1'b0;
`endif

  // A software request only restarts the stretch; the sync chain is not re-run.
  assign sw_act    = sw_req && (state_q != SYNC);
  assign hold_done = (state_q == HOLD)    && (cnt_q == HOLD_LAST);
  assign gap_done  = (state_q == RELEASE) && (cnt_q == GAP_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      all_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      all_q   <= all_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (sw_act) begin
      state_d = HOLD;
    end else begin
      case (state_q)
        SYNC:    if (rst_sync_n) state_d = HOLD;
        HOLD:    if (hold_done) state_d = (NUM_DOMAINS == 1) ? RUN : RELEASE;
        RELEASE: if (gap_done && (idx_q == IDX_LAST)) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    rst_d  = rst_q;
    all_d  = all_q;
    busy_d = busy_q;
    if (sw_act) begin
      cnt_d  = '0;
      idx_d  = '0;
      rst_d  = '0;
      all_d  = 1'b0;
      busy_d = 1'b1;
    end else begin
      case (state_q)
        SYNC: cnt_d = '0;
        HOLD: begin
          if (hold_done) begin
            cnt_d    = '0;
            idx_d    = IDX_W'(1);
            rst_d[0] = 1'b1;
            if (NUM_DOMAINS == 1) begin
              all_d  = 1'b1;
              busy_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (gap_done) begin
            cnt_d = '0;
            for (int k = 0; k < NUM_DOMAINS; k++) begin
              if (idx_q == IDX_W'(k)) rst_d[k] = 1'b1;
            end
            if (idx_q == IDX_LAST) begin
              all_d  = 1'b1;
              busy_d = 1'b0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  assign o_rst_n        = rst_q;
  assign o_all_released = all_q;
  assign o_seq_busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer : directed bench for reset_sequencer (default and
//                      single-domain configurations side by side)
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw = 1'b0;
  logic [2:0] rst0;
  logic       all0, busy0;
  logic [0:0] rst1;
  logic       all1, busy1;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  reset_sequencer dut0 (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_sw_rst_req   (sw),
    .o_rst_n        (rst0),
    .o_all_released (all0),
    .o_seq_busy     (busy0)
  );

  reset_sequencer #(
    .SYNC_STAGES (3),
    .NUM_DOMAINS (1),
    .HOLD_CYCLES (1),
    .GAP_CYCLES  (4)
  ) dut1 (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_sw_rst_req   (sw),
    .o_rst_n        (rst1),
    .o_all_released (all1),
    .o_seq_busy     (busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] x;
    logic       y;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if ({rst0, all0, busy0} !== 5'b00001) begin
      miscompares++;
      $display("FAIL reset_state3 got=%b exp=%b", {rst0, all0, busy0}, 5'b00001);
    end
    vectors++;
    if ({rst1, all1, busy1} !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_state1 got=%b exp=%b", {rst1, all1, busy1}, 3'b001);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      x = {(e >= 27), (e >= 23), (e >= 19)};
      y = (e >= 5);
      vectors++;
      if ({rst0, all0, busy0} !== {x, (x == 3'b111), (x != 3'b111)}) begin
        miscompares++;
        $display("FAIL poweron3 E%0d got=%b exp=%b", e, {rst0, all0, busy0},
                 {x, (x == 3'b111), (x != 3'b111)});
      end
      vectors++;
      if ({rst1, all1, busy1} !== {y, y, !y}) begin
        miscompares++;
        $display("FAIL poweron1 E%0d got=%b exp=%b", e, {rst1, all1, busy1}, {y, y, !y});
      end
    end
  endtask

  task automatic test_async_mid();
    logic [2:0] x;
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (24) tick();
    vectors++;
    if (rst0 !== 3'b011) begin
      miscompares++;
      $display("FAIL async_pre E24 got=%b exp=%b", rst0, 3'b011);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({rst0, all0, busy0} !== 5'b00001) begin
      miscompares++;
      $display("FAIL async_clear got=%b exp=%b", {rst0, all0, busy0}, 5'b00001);
    end
    #2;
    rst_n = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      x = {(e >= 27), (e >= 23), (e >= 19)};
      vectors++;
      if ({rst0, all0, busy0} !== {x, (x == 3'b111), (x != 3'b111)}) begin
        miscompares++;
        $display("FAIL async_repeat E%0d got=%b exp=%b", e, {rst0, all0, busy0},
                 {x, (x == 3'b111), (x != 3'b111)});
      end
    end
  endtask

`ifdef RST_SEQ_SW_RST_EN
  task automatic test_sw_pulse();
    logic [2:0] x;
    sw = 1'b1;
    tick();
    sw = 1'b0;
    vectors++;
    if ({rst0, all0, busy0} !== 5'b00001) begin
      miscompares++;
      $display("FAIL sw_pulse_clear got=%b exp=%b", {rst0, all0, busy0}, 5'b00001);
    end
    for (int j = 1; j <= 30; j++) begin
      tick();
      x = {(j >= 24), (j >= 20), (j >= 16)};
      vectors++;
      if ({rst0, all0, busy0} !== {x, (x == 3'b111), (x != 3'b111)}) begin
        miscompares++;
        $display("FAIL sw_pulse N+%0d got=%b exp=%b", j, {rst0, all0, busy0},
                 {x, (x == 3'b111), (x != 3'b111)});
      end
    end
  endtask

  task automatic test_sw_hold();
    logic [2:0] x;
    sw = 1'b1;
    for (int j = 0; j <= 9; j++) begin
      tick();
      vectors++;
      if ({rst0, all0, busy0} !== 5'b00001) begin
        miscompares++;
        $display("FAIL sw_hold_held N+%0d got=%b exp=%b", j, {rst0, all0, busy0}, 5'b00001);
      end
    end
    sw = 1'b0;
    for (int j = 10; j <= 35; j++) begin
      tick();
      x = {(j >= 33), (j >= 29), (j >= 25)};
      vectors++;
      if ({rst0, all0, busy0} !== {x, (x == 3'b111), (x != 3'b111)}) begin
        miscompares++;
        $display("FAIL sw_hold N+%0d got=%b exp=%b", j, {rst0, all0, busy0},
                 {x, (x == 3'b111), (x != 3'b111)});
      end
    end
  endtask

  task automatic test_sw_release();
    logic [2:0] x;
    sw = 1'b1;
    tick();
    sw = 1'b0;
    repeat (18) tick();
    vectors++;
    if (rst0 !== 3'b001) begin
      miscompares++;
      $display("FAIL sw_rel_pre got=%b exp=%b", rst0, 3'b001);
    end
    sw = 1'b1;
    tick();
    sw = 1'b0;
    vectors++;
    if ({rst0, all0, busy0} !== 5'b00001) begin
      miscompares++;
      $display("FAIL sw_rel_clear got=%b exp=%b", {rst0, all0, busy0}, 5'b00001);
    end
    for (int j = 1; j <= 26; j++) begin
      tick();
      x = {(j >= 24), (j >= 20), (j >= 16)};
      vectors++;
      if ({rst0, all0, busy0} !== {x, (x == 3'b111), (x != 3'b111)}) begin
        miscompares++;
        $display("FAIL sw_rel M+%0d got=%b exp=%b", j, {rst0, all0, busy0},
                 {x, (x == 3'b111), (x != 3'b111)});
      end
    end
  endtask
`else
  task automatic test_sw_ignored();
    logic [2:0] x;
    sw = 1'b1;
    tick();
    sw = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      tick();
      vectors++;
      if ({rst0, all0, busy0} !== 5'b11110) begin
        miscompares++;
        $display("FAIL sw_ign_run N+%0d got=%b exp=%b", j, {rst0, all0, busy0}, 5'b11110);
      end
    end
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      sw = (e == 10);
      tick();
      x = {(e >= 27), (e >= 23), (e >= 19)};
      vectors++;
      if ({rst0, all0, busy0} !== {x, (x == 3'b111), (x != 3'b111)}) begin
        miscompares++;
        $display("FAIL sw_ign_hold E%0d got=%b exp=%b", e, {rst0, all0, busy0},
                 {x, (x == 3'b111), (x != 3'b111)});
      end
    end
    sw = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_async_mid();
`ifdef RST_SEQ_SW_RST_EN
    test_sw_pulse();
    test_sw_hold();
    test_sw_release();
`else
    test_sw_ignored();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
